// File: rtl/mesh_endpoint_if.sv
// Bundles the mesh link and host-side handshake signals of a mesh terminal.
// The slave view belongs to the endpoint; the master view drives it.
interface mesh_endpoint_if #(
    parameter int pckg_sz = 40
);
    // Mesh side
    logic               pndng_i_in;
    logic [pckg_sz-1:0] data_out_i_in;
    logic               popin;
    logic               pndng;
    logic [pckg_sz-1:0] data_out;
    logic               pop;

    // Host transmit side
    logic                tx_valid;
    logic                tx_ready;
    logic [3:0]          tx_row;
    logic [3:0]          tx_col;
    logic                tx_mode;
    logic [pckg_sz-18:0] tx_payload;

    // Host receive side
    logic               rx_valid;
    logic [pckg_sz-1:0] rx_data;
    logic               rx_misroute;
    logic               rx_ready;

    modport slave (
        output pndng_i_in, data_out_i_in, pop,
        input  popin, pndng, data_out,
        input  tx_valid, tx_row, tx_col, tx_mode, tx_payload,
        output tx_ready,
        output rx_valid, rx_data, rx_misroute,
        input  rx_ready
    );

    modport master (
        input  pndng_i_in, data_out_i_in, pop,
        output popin, pndng, data_out,
        output tx_valid, tx_row, tx_col, tx_mode, tx_payload,
        input  tx_ready,
        input  rx_valid, rx_data, rx_misroute,
        output rx_ready
    );
endinterface

// File: rtl/mesh_endpoint.sv
// Mesh terminal endpoint: formats host packets into a TX FIFO offered to the
// mesh, and pulls mesh packets one at a time into a single-entry RX holding
// register with address checking and saturating traffic counters.
module mesh_endpoint #(
    parameter int pckg_sz    = 40,
    parameter int fifo_depth = 4,
    parameter int ROW_ID     = 0,
    parameter int COL_ID     = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    mesh_endpoint_if.slave       bus,
    output logic [15:0]          tx_count,
    output logic [15:0]          rx_count,
    output logic [15:0]          rx_err
);

    localparam int PTR_W = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
    localparam int CNT_W = $clog2(fifo_depth + 1);
    localparam logic [7:0] MY_ADDR = {ROW_ID[3:0], COL_ID[3:0]};

    typedef enum logic {
        RX_IDLE,
        RX_FULL
    } rx_state_t;

    // Saturating 16-bit increment shared by all traffic counters.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Pointer advance with wrap at fifo_depth (depth need not be a power of 2).
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(fifo_depth - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // ---------------- TX FIFO ----------------
    logic [pckg_sz-1:0] mem_q [fifo_depth];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               full, empty, push, tx_pop;
    logic [pckg_sz-1:0] tx_pkt;

    assign full   = (cnt_q == CNT_W'(fifo_depth));
    assign empty  = (cnt_q == '0);
    assign push   = bus.tx_valid && !full;
    assign tx_pop = bus.popin && !empty;
    assign tx_pkt = {8'h00, bus.tx_row, bus.tx_col, bus.tx_mode, bus.tx_payload};

    assign bus.tx_ready      = !full;
    assign bus.pndng_i_in    = !empty;
    assign bus.data_out_i_in = mem_q[rd_ptr_q];

    // Next FIFO pointers and occupancy from the push/pop pair.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push)
            wr_ptr_d = ptr_next(wr_ptr_q);
        if (tx_pop)
            rd_ptr_d = ptr_next(rd_ptr_q);
        case ({push, tx_pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // FIFO control state; reset empties the queue.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // FIFO storage; contents are meaningless while empty, so no reset.
    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= tx_pkt;
    end

    // ---------------- RX holding register ----------------
    rx_state_t          state_q, state_d;
    logic [pckg_sz-1:0] rx_data_q;
    logic               mis_q;
    logic               capture;
    logic               mis_now;

    assign mis_now = (bus.data_out[pckg_sz-9:pckg_sz-16] != MY_ADDR);

    // RX next state; pop is gated by reset so it drops immediately.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            RX_IDLE: begin
                capture = bus.pndng && reset;
                if (bus.pndng)
                    state_d = RX_FULL;
            end
            RX_FULL: begin
                if (bus.rx_ready)
                    state_d = RX_IDLE;
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign bus.pop         = capture;
    assign bus.rx_valid    = (state_q == RX_FULL);
    assign bus.rx_data     = rx_data_q;
    assign bus.rx_misroute = (state_q == RX_FULL) && mis_q;

    // RX state, captured packet and its misroute flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= RX_IDLE;
            rx_data_q <= '0;
            mis_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                rx_data_q <= bus.data_out;
                mis_q     <= mis_now;
            end
        end
    end

    // ---------------- Counters ----------------
    logic [15:0] tx_count_q, rx_count_q, rx_err_q;

    // Saturating traffic counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_count_q <= '0;
            rx_count_q <= '0;
            rx_err_q   <= '0;
        end else begin
            if (tx_pop)
                tx_count_q <= sat_inc(tx_count_q);
            if (capture)
                rx_count_q <= sat_inc(rx_count_q);
            if (capture && mis_now)
                rx_err_q <= sat_inc(rx_err_q);
        end
    end

    assign tx_count = tx_count_q;
    assign rx_count = rx_count_q;
    assign rx_err   = rx_err_q;

endmodule

// File: doc/mesh_endpoint.md
MESH_ENDPOINT -- requirements
Module: mesh_endpoint

Interface
REQ-001 SHALL have parameter pckg_sz, default 40, packet width in bits.
REQ-002 SHALL have parameter fifo_depth, default 4, TX FIFO entries.
REQ-003 SHALL have parameter ROW_ID, default 0, 4-bit row address of this terminal.
REQ-004 SHALL have parameter COL_ID, default 1, 4-bit column address of this terminal.
REQ-005 SHALL have ports:
- clk  in  1  clock, all logic on rising edge; one clock domain.
- reset  in  1  asynchronous, active-low.
- pndng_i_in  out  1  TX packet pending toward the mesh.
- data_out_i_in  out  pckg_sz  TX FIFO head toward the mesh.
- popin  in  1  mesh consumes the TX head.
- pndng  in  1  mesh holds a packet for this terminal.
- data_out  in  pckg_sz  mesh packet for this terminal.
- pop  out  1  consume the mesh packet.
- tx_valid  in  1  host offers a packet.
- tx_ready  out  1  TX FIFO can accept.
- tx_row  in  4  destination row.
- tx_col  in  4  destination column.
- tx_mode  in  1  routing mode bit.
- tx_payload  in  pckg_sz-17  payload.
- rx_valid  out  1  received packet held.
- rx_data  out  pckg_sz  received packet.
- rx_misroute  out  1  held packet's address differs from ROW_ID/COL_ID.
- rx_ready  in  1  host accepts the held packet.
- tx_count  out  16  packets taken by the mesh.
- rx_count  out  16  packets popped from the mesh.
- rx_err  out  16  misrouted packets received.

Function
REQ-006 SHALL format each packet as [pckg_sz-1:pckg_sz-8]=8'h00 (next jump), [pckg_sz-9:pckg_sz-12]=tx_row, [pckg_sz-13:pckg_sz-16]=tx_col, [pckg_sz-17]=tx_mode, remaining low bits=tx_payload.
REQ-007 SHALL drive tx_ready = !full; a push occurs on a rising edge with tx_valid && tx_ready.
REQ-008 SHALL drive pndng_i_in = !empty and data_out_i_in = current FIFO head, both combinational from registered FIFO state, with data stable while pndng_i_in=1.
REQ-009 SHALL remove the head on a rising edge with popin=1 && !empty; popin while empty is ignored with no state change.
REQ-010 SHALL perform push and pop in the same cycle when not full and not empty, leaving occupancy unchanged; when full, the push is refused even if popin=1.
REQ-011 SHALL use wrap-around read/write pointers modulo fifo_depth, with preserved FIFO order.
REQ-012 SHALL implement the RX FSM:
- RX_IDLE: pop = pndng (combinational); when pndng=1, capture data_out into rx_data on that edge and go to RX_FULL.
- RX_FULL: rx_valid=1 and pop=0; on rx_ready=1, go to RX_IDLE.
- pop SHALL be 0 in every state other than RX_IDLE.
REQ-013 SHALL produce one pop per packet with at least one cycle between pops, giving maximum RX throughput of 1 packet per 2 cycles.
REQ-014 SHALL set rx_misroute in RX_FULL when captured bits [pckg_sz-9:pckg_sz-16] != {ROW_ID,COL_ID}; the packet is still delivered.
REQ-015 SHALL increment tx_count on each accepted popin and rx_count on each pop; each counter saturates at 16'hFFFF.
REQ-016 SHALL increment rx_err on the capture edge of each misrouted packet, saturating at 16'hFFFF.

Reset
REQ-017 SHALL, while reset=0, immediately force all of the following, independent of clk:
- FIFO empty, so pndng_i_in=0 and tx_ready=1;
- RX FSM in RX_IDLE with rx_valid=0, rx_misroute=0 and rx_data=0;
- pop=0;
- all counters at 0.
REQ-018 SHALL, if reset is asserted mid-transfer, drop any held or queued packets; operation resumes on the first rising edge after reset=1.

Verification
REQ-019 Push row=0,col=1,mode=1,payload=23'h00ABCD with pckg_sz=40 -> data_out_i_in=40'h00_01_80ABCD and pndng_i_in=1 on the next cycle; popin one cycle -> pndng_i_in=0 and tx_count=1.
REQ-020 Push 4 packets with no popin -> tx_ready=0 after the 4th; a 5th push is refused; with popin and tx_valid both held high, one pop and one push occur per cycle; order is preserved across pointer wrap.
REQ-021 Hold pndng=1 with data_out=40'h00_01_000055 and rx_ready=0 -> exactly one pop, rx_valid=1, rx_misroute=0, rx_count=1; pop stays 0 until rx_ready is asserted.
REQ-022 Deliver a packet addressed row=2,col=3 -> rx_misroute=1 and rx_err=1; rx_data equals data_out exactly.
REQ-023 Pulse reset=0 asynchronously, between clock edges, with 2 packets queued and rx_valid=1 -> pndng_i_in, rx_valid, pop and all counters go to 0 without a clock edge.
REQ-024 Hold pndng=1 and rx_ready=1 continuously for 8 packets -> pop asserted on alternate cycles only, rx_count=8.
